// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, buffers Icache hits in a small
// queue feeding decode, flushes on redirect and counts Icache wait cycles.
module fetch_unit #(
   parameter int FQ_DEPTH     = 4,
   parameter int LOG_FQ_DEPTH = 2,
   parameter int STAT_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [63:0]             i_entry_pc,
   output logic [63:0]             o_fetch_addr,
   input  logic [31:0]             i_icache_inst,
   input  logic                    i_icache_valid,
   input  logic                    i_redirect_valid,
   input  logic [63:0]             i_redirect_pc,
   output logic                    o_dec_valid,
   input  logic                    i_dec_ready,
   output logic [31:0]             o_dec_inst,
   output logic [63:0]             o_dec_pc,
   output logic [LOG_FQ_DEPTH:0]   o_fq_count,
   output logic [STAT_WIDTH-1:0]   o_stat_miss_cyc
);

   localparam logic [LOG_FQ_DEPTH:0] CNT_FULL = (LOG_FQ_DEPTH+1)'(FQ_DEPTH);

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

   fq_entry_t                 r_fq [FQ_DEPTH];
   logic [63:0]               r_pc;
   logic [LOG_FQ_DEPTH-1:0]   r_head;
   logic [LOG_FQ_DEPTH-1:0]   r_tail;
   logic [LOG_FQ_DEPTH:0]     r_count;
   logic [STAT_WIDTH-1:0]     r_stat;

   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_miss;

   // Full blocks the push even if decode pops this cycle; the slot refills next cycle.
   assign w_full = (r_count == CNT_FULL);
   assign w_push = i_icache_valid & ~w_full & ~i_redirect_valid;
   assign w_pop  = (r_count != '0) & i_dec_ready;
   assign w_miss = ~i_icache_valid & ~w_full & ~i_redirect_valid;

   assign o_fetch_addr    = r_pc;
   assign o_dec_valid     = (r_count != '0);
   assign o_dec_inst      = r_fq[r_head].inst;
   assign o_dec_pc        = r_fq[r_head].pc;
   assign o_fq_count      = r_count;
   assign o_stat_miss_cyc = r_stat;

   // Storage needs no reset: pointers and count define which slots are live.
   always_ff @(posedge clk) begin
      if (w_push)
         r_fq[r_tail] <= '{pc: r_pc, inst: i_icache_inst};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= i_entry_pc & ~64'h3;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_redirect_valid) begin
         r_pc    <= i_redirect_pc & ~64'h3;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
            r_pc   <= r_pc + 64'd4;
         end
         if (w_pop)
            r_head <= r_head + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Saturating: holds at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset)
         r_stat <= '0;
      else if (w_miss && !(&r_stat))
         r_stat <= r_stat + 1'b1;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random stimulus for fetch_unit, checked every cycle against
// a queue-based reference model of the fetch stage.
module tb_fetch_unit;

   localparam int FQ_DEPTH = 4;
   localparam int LOG_FQ   = 2;
   localparam int STAT_W   = 5;
   localparam int STAT_MAX = (1 << STAT_W) - 1;

   logic               clk = 1'b0;
   logic               reset;
   logic [63:0]        entry_pc;
   logic [63:0]        fetch_addr;
   logic [31:0]        icache_inst;
   logic               icache_valid;
   logic               redirect_valid;
   logic [63:0]        redirect_pc;
   logic               dec_valid;
   logic               dec_ready;
   logic [31:0]        dec_inst;
   logic [63:0]        dec_pc;
   logic [LOG_FQ:0]    fq_count;
   logic [STAT_W-1:0]  stat_miss_cyc;

   fetch_unit #(.FQ_DEPTH(FQ_DEPTH), .LOG_FQ_DEPTH(LOG_FQ), .STAT_WIDTH(STAT_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_entry_pc      (entry_pc),
      .o_fetch_addr    (fetch_addr),
      .i_icache_inst   (icache_inst),
      .i_icache_valid  (icache_valid),
      .i_redirect_valid(redirect_valid),
      .i_redirect_pc   (redirect_pc),
      .o_dec_valid     (dec_valid),
      .i_dec_ready     (dec_ready),
      .o_dec_inst      (dec_inst),
      .o_dec_pc        (dec_pc),
      .o_fq_count      (fq_count),
      .o_stat_miss_cyc (stat_miss_cyc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        m_q[$];
   logic [63:0] m_pc = '0;
   int          m_stat = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("fetch_addr", fetch_addr, m_pc);
      chk("fq_count", 64'(fq_count), 64'(m_q.size()));
      chk("dec_valid", 64'(dec_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("dec_pc", dec_pc, m_q[0].pc);
         chk("dec_inst", 64'(dec_inst), 64'(m_q[0].inst));
      end
      chk("stat_miss_cyc", 64'(stat_miss_cyc), 64'(m_stat));
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge.
   task automatic cycle(input bit rst, input logic [63:0] epc, input bit iv,
                        input logic [31:0] inst, input bit rv,
                        input logic [63:0] rpc, input bit rdy);
      bit full;
      reset = rst; entry_pc = epc; icache_valid = iv; icache_inst = inst;
      redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
      full = (m_q.size() == FQ_DEPTH);
      if (rst) begin
         m_pc = {epc[63:2], 2'b00};
         m_q.delete();
         m_stat = 0;
      end else if (rv) begin
         m_pc = {rpc[63:2], 2'b00};
         m_q.delete();
      end else begin
         if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
         if (iv && !full) begin
            m_q.push_back('{pc: m_pc, inst: inst});
            m_pc = m_pc + 64'd4;
         end
         if (!iv && !full && m_stat < STAT_MAX) m_stat++;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic hit(input bit rdy);
      cycle(1'b0, 64'h0, 1'b1, $urandom, 1'b0, 64'h0, rdy);
   endtask

   int stat0;

   initial begin
      reset = 1'b1; entry_pc = '0; icache_valid = 1'b0; icache_inst = '0;
      redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

      // Reset with unaligned entry PC; Icache always hits.
      cycle(1'b1, 64'h1003, 1'b1, $urandom, 1'b0, 64'h0, 1'b1);
      cycle(1'b1, 64'h1003, 1'b1, $urandom, 1'b0, 64'h0, 1'b1);
      chk("reset_fetch_addr", fetch_addr, 64'h1000);
      chk("reset_dec_valid", 64'(dec_valid), 64'h0);
      hit(1'b1);
      chk("first_dec_pc", dec_pc, 64'h1000);
      for (int i = 0; i < 5; i++) hit(1'b1);

      // Decode stalls: queue fills and PC freezes.
      cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 64'h2000, 1'b0);
      for (int i = 0; i < 7; i++) hit(1'b0);
      chk("full_count", 64'(fq_count), 64'd4);
      chk("full_fetch_addr", fetch_addr, 64'h2010);
      hit(1'b1);
      chk("pop_no_bypass", 64'(fq_count), 64'd3);
      hit(1'b0);
      chk("refill", 64'(fq_count), 64'd4);

      // Redirect with three queued entries.
      cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 64'h3000, 1'b0);
      for (int i = 0; i < 3; i++) hit(1'b0);
      cycle(1'b0, 64'h0, 1'b1, $urandom, 1'b1, 64'h8002, 1'b1);
      chk("redir_count", 64'(fq_count), 64'd0);
      chk("redir_fetch_addr", fetch_addr, 64'h8000);
      hit(1'b0);
      chk("redir_first_pc", dec_pc, 64'h8000);

      // Miss stall with room in the queue, then stall while full.
      stat0 = int'(stat_miss_cyc);
      for (int i = 0; i < 10; i++) cycle(1'b0, 64'h0, 1'b0, $urandom, 1'b0, 64'h0, 1'b0);
      chk("miss_delta", 64'(int'(stat_miss_cyc) - stat0), 64'd10);
      chk("miss_addr_hold", fetch_addr, 64'h8004);
      for (int i = 0; i < 3; i++) hit(1'b0);
      stat0 = int'(stat_miss_cyc);
      for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b0, $urandom, 1'b0, 64'h0, 1'b0);
      chk("full_miss_delta", 64'(int'(stat_miss_cyc) - stat0), 64'd0);

      // PC wraps at the top of the address space.
      cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      hit(1'b0);
      chk("wrap_dec_pc", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_fetch_addr", fetch_addr, 64'h0);

      // Reset beats a same-cycle redirect while full.
      for (int i = 0; i < 5; i++) hit(1'b0);
      cycle(1'b1, 64'h4001, 1'b1, $urandom, 1'b1, 64'h9000, 1'b1);
      chk("rst_redir_addr", fetch_addr, 64'h4000);
      chk("rst_redir_count", 64'(fq_count), 64'd0);
      cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);

      // Random traffic; long miss runs drive the narrow counter into saturation.
      for (int i = 0; i < 2000; i++) begin
         logic [63:0] rpc;
         rpc = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         cycle($urandom_range(0, 199) == 0, {$urandom, $urandom},
               $urandom_range(0, 9) < 6, $urandom,
               $urandom_range(0, 24) == 0, rpc, $urandom_range(0, 1) == 1);
      end
      chk("stat_saturated", 64'(stat_miss_cyc), 64'(m_stat));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
